// File: rtl/mat_read_sequencer.sv
// Read-port initiator for the matrix memory: fetches elements three at a time
// through the asynchronous read lanes, then streams them out over valid/ready.
module mat_read_sequencer #(
    parameter int ROW    = 2,
    parameter int COLUMN = 2,
    parameter int SIZE   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            read,
    output logic [7:0]      read_address0,
    output logic [7:0]      read_address1,
    output logic [7:0]      read_address2,
    input  logic [SIZE-1:0] data0,
    input  logic [SIZE-1:0] data1,
    input  logic [SIZE-1:0] data2,
    output logic [SIZE-1:0] out_data,
    output logic [7:0]      out_index,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    localparam logic [7:0] N = 8'(ROW * COLUMN);

    typedef enum logic [2:0] {IDLE, SETUP, READ, DRAIN, FIN} state_t;

    state_t          state_q, state_d;
    logic [7:0]      base_q, base_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [SIZE-1:0] cap0_q, cap0_d;
    logic [SIZE-1:0] cap1_q, cap1_d;
    logic [SIZE-1:0] cap2_q, cap2_d;

    logic [7:0]      remaining;
    logic [1:0]      lane_inc;
    logic [7:0]      cur_index;
    logic            addr_en;

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge value of its neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            cap0_q  <= '0;
            cap1_q  <= '0;
            cap2_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            cap0_q  <= cap0_d;
            cap1_q  <= cap1_d;
            cap2_q  <= cap2_d;
        end
    end

    assign remaining = N - base_q;
    assign lane_inc  = lane_q + 2'd1;
    assign cur_index = base_q + {6'd0, lane_q};

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        cap0_d  = cap0_q;
        cap1_d  = cap1_q;
        cap2_d  = cap2_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = READ;
            READ: begin
                cap0_d  = data0;
                cap1_d  = data1;
                cap2_d  = data2;
                cnt_d   = (remaining >= 8'd3) ? 2'd3 : remaining[1:0];
                lane_d  = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_ready) begin
                    if (lane_inc == cnt_q) begin
                        // More elements remain past this batch: fetch the next three.
                        if ((base_q + {6'd0, cnt_q}) < N) begin
                            base_d  = base_q + 8'd3;
                            state_d = SETUP;
                        end else begin
                            state_d = FIN;
                        end
                    end else begin
                        lane_d = lane_inc;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses are driven from SETUP so they settle a full cycle before read rises.
    assign addr_en       = (state_q == SETUP) || (state_q == READ);
    assign read_address0 = addr_en ? base_q          : 8'd0;
    assign read_address1 = addr_en ? base_q + 8'd1   : 8'd0;
    assign read_address2 = addr_en ? base_q + 8'd2   : 8'd0;
    assign read          = (state_q == READ);

    assign out_valid = (state_q == DRAIN);
    assign out_index = out_valid ? cur_index : 8'd0;
    assign out_last  = out_valid && (cur_index == N - 8'd1);

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            unique case (lane_q)
                2'd0:    out_data = cap0_q;
                2'd1:    out_data = cap1_q;
                default: out_data = cap2_q;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);

endmodule

// File: tb/tb_mat_read_sequencer.sv
// Bench for mat_read_sequencer: a 2x2 and a 3x3 instance, each fed by a memory
// model that returns real data only while read is high.
module tb_mat_read_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_s [2];
    logic       read_s  [2];
    logic [7:0] a0 [2], a1 [2], a2 [2];
    logic [7:0] d0 [2], d1 [2], d2 [2];
    logic [7:0] od [2], oi [2];
    logic       ov [2], ol [2], ordy [2], busy_s [2], done_s [2];

    logic [7:0] mem [2][256];

    mat_read_sequencer #(.ROW(2), .COLUMN(2), .SIZE(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_s[0]), .read(read_s[0]),
        .read_address0(a0[0]), .read_address1(a1[0]), .read_address2(a2[0]),
        .data0(d0[0]), .data1(d1[0]), .data2(d2[0]),
        .out_data(od[0]), .out_index(oi[0]), .out_valid(ov[0]), .out_last(ol[0]),
        .out_ready(ordy[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    mat_read_sequencer #(.ROW(3), .COLUMN(3), .SIZE(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_s[1]), .read(read_s[1]),
        .read_address0(a0[1]), .read_address1(a1[1]), .read_address2(a2[1]),
        .data0(d0[1]), .data1(d1[1]), .data2(d2[1]),
        .out_data(od[1]), .out_index(oi[1]), .out_valid(ov[1]), .out_last(ol[1]),
        .out_ready(ordy[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    // Data is only meaningful while read is high; otherwise the lanes carry junk.
    assign d0[0] = read_s[0] ? mem[0][a0[0]] : 8'hA5;
    assign d1[0] = read_s[0] ? mem[0][a1[0]] : 8'hA5;
    assign d2[0] = read_s[0] ? mem[0][a2[0]] : 8'hA5;
    assign d0[1] = read_s[1] ? mem[1][a0[1]] : 8'hA5;
    assign d1[1] = read_s[1] ? mem[1][a1[1]] : 8'hA5;
    assign d2[1] = read_s[1] ? mem[1][a2[1]] : 8'hA5;

    // ---------------- monitor: logs reads, handshakes, done pulses ----------------
    logic [7:0] r_a0 [2][256], r_a1 [2][256], r_a2 [2][256];
    logic [7:0] s_i [2][1024], s_d [2][1024];
    logic       s_l [2][1024];
    int         rd_n [2]      = '{0, 0};
    int         s_n [2]       = '{0, 0};
    int         done_n [2]    = '{0, 0};
    int         setup_err [2] = '{0, 0};
    int         hold_err [2]  = '{0, 0};
    logic [7:0] pa0 [2], pa1 [2], pa2 [2], ph_i [2], ph_d [2];
    logic       prd [2]       = '{1'b0, 1'b0};
    logic       pvh [2]       = '{1'b0, 1'b0};
    logic       ph_l [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (read_s[d] && rd_n[d] < 256) begin
                r_a0[d][rd_n[d]] <= a0[d];
                r_a1[d][rd_n[d]] <= a1[d];
                r_a2[d][rd_n[d]] <= a2[d];
                rd_n[d]          <= rd_n[d] + 1;
            end
            if (read_s[d] && !prd[d] && {a0[d], a1[d], a2[d]} != {pa0[d], pa1[d], pa2[d]})
                setup_err[d] <= setup_err[d] + 1;
            if (ov[d] && ordy[d] && s_n[d] < 1024) begin
                s_i[d][s_n[d]] <= oi[d];
                s_d[d][s_n[d]] <= od[d];
                s_l[d][s_n[d]] <= ol[d];
                s_n[d]         <= s_n[d] + 1;
            end
            if (pvh[d] && !(ov[d] && oi[d] == ph_i[d] && od[d] == ph_d[d] && ol[d] == ph_l[d]))
                hold_err[d] <= hold_err[d] + 1;
            if (done_s[d]) done_n[d] <= done_n[d] + 1;
            pa0[d]  <= a0[d];
            pa1[d]  <= a1[d];
            pa2[d]  <= a2[d];
            prd[d]  <= read_s[d];
            pvh[d]  <= ov[d] && !ordy[d] && !rst;
            ph_i[d] <= oi[d];
            ph_d[d] <= od[d];
            ph_l[d] <= ol[d];
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int n_of(input int d);
        return (d == 0) ? 4 : 9;
    endfunction

    // Reference: a full frame is elements 0..N-1 in order, ceil(N/3) single-cycle
    // reads at bases 0,3,6,..., and exactly one done pulse.
    task automatic expect_frame(input int d, input int s0, input int r0, input int dn0,
                                input string name);
        int n, nb;
        n  = n_of(d);
        nb = (n + 2) / 3;
        check({name, " stream_len"}, 32'(s_n[d] - s0), 32'(n));
        for (int k = 0; k < n; k++)
            if (s0 + k < s_n[d])
                check({name, " elem"},
                      {15'd0, s_i[d][s0+k], s_d[d][s0+k], s_l[d][s0+k]},
                      {15'd0, 8'(k), mem[d][k], k == n - 1});
        check({name, " read_cycles"}, 32'(rd_n[d] - r0), 32'(nb));
        for (int j = 0; j < nb; j++)
            if (r0 + j < rd_n[d])
                check({name, " read_addr"},
                      {8'd0, r_a0[d][r0+j], r_a1[d][r0+j], r_a2[d][r0+j]},
                      {8'd0, 8'(3*j), 8'(3*j+1), 8'(3*j+2)});
        check({name, " done_pulses"}, 32'(done_n[d] - dn0), 32'd1);
    endtask

    task automatic wait_done(input int d, input int dn0, input bit rnd, input string name);
        int cyc;
        cyc = 0;
        while (cyc < 300) begin
            @(negedge clk); #1;
            if (done_n[d] != dn0) break;
            @(posedge clk); #1;
            ordy[d] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            cyc++;
        end
        check({name, " done_seen"}, 32'(done_n[d] != dn0), 32'd1);
        @(posedge clk); #1;
        ordy[d] = 1'b1;
        @(negedge clk);
        check({name, " idle_after"}, 32'(busy_s[d]), 32'd0);
    endtask

    task automatic run(input int d, input bit rnd, input string name);
        int s0, r0, dn0;
        s0 = s_n[d]; r0 = rd_n[d]; dn0 = done_n[d];
        @(posedge clk); #1;
        start_s[d] = 1'b1;
        ordy[d]    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        wait_done(d, dn0, rnd, name);
        @(negedge clk); #1;
        expect_frame(d, s0, r0, dn0, name);
    endtask

    typedef struct {
        logic       start;
        logic       rdy;
        logic       e_read;
        logic       chk_addr;
        logic [7:0] e_addr;
        logic       e_valid;
        logic [7:0] e_idx;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int s0, r0, dn0, cyc;
        logic [15:0] spat;

        rst = 1'b1;
        start_s = '{1'b0, 1'b0};
        ordy    = '{1'b1, 1'b1};
        for (int k = 0; k < 256; k++) begin
            mem[0][k] = 8'(8'hE0 + k);
            mem[1][k] = 8'(8'hC0 + k);
        end
        mem[0][0] = 8'd10; mem[0][1] = 8'd20; mem[0][2] = 8'd30; mem[0][3] = 8'd40;
        for (int k = 0; k < 9; k++) mem[1][k] = 8'(k + 1);

        // Reset state, observed while rst is still held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst ctrl", {27'd0, read_s[d], ov[d], ol[d], busy_s[d], done_s[d]}, 32'd0);
            check("rst addr", {8'd0, a0[d], a1[d], a2[d]}, 32'd0);
            check("rst out",  {16'd0, oi[d], od[d]}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic 2x2 trace, cycle by cycle; start is sampled at the end of row 0.
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 0, 0, 0,  0, 0, 1, 0};
        tbl[2]  = '{0, 1, 1, 1, 0, 0, 0,  0, 0, 1, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 1, 0, 10, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 1, 1, 20, 0, 1, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 1, 2, 30, 0, 1, 0};
        tbl[6]  = '{0, 1, 0, 1, 3, 0, 0,  0, 0, 1, 0};
        tbl[7]  = '{0, 1, 1, 1, 3, 0, 0,  0, 0, 1, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 1, 3, 40, 1, 1, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            start_s[0] = tbl[i].start;
            ordy[0]    = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("basic ctrl row%0d", i),
                  {27'd0, read_s[0], ov[0], ol[0], busy_s[0], done_s[0]},
                  {27'd0, tbl[i].e_read, tbl[i].e_valid, tbl[i].e_last, tbl[i].e_busy, tbl[i].e_done});
            if (tbl[i].e_valid)
                check($sformatf("basic data row%0d", i), {16'd0, oi[0], od[0]},
                      {16'd0, tbl[i].e_idx, tbl[i].e_data});
            if (tbl[i].chk_addr)
                check($sformatf("basic addr row%0d", i), {8'd0, a0[0], a1[0], a2[0]},
                      {8'd0, tbl[i].e_addr, 8'(tbl[i].e_addr + 1), 8'(tbl[i].e_addr + 2)});
        end

        // Backpressure: ready low for the first 5 valid cycles.
        s0 = s_n[0]; r0 = rd_n[0]; dn0 = done_n[0];
        @(posedge clk); #1;
        start_s[0] = 1'b1;
        ordy[0]    = 1'b0;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!ov[0] && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("bp valid_rose", 32'(ov[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp hold", {15'd0, ov[0], oi[0], od[0], read_s[0]}, {15'd0, 1'b1, 8'd0, 8'd10, 1'b0});
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        wait_done(0, dn0, 1'b0, "bp");
        @(negedge clk); #1;
        expect_frame(0, s0, r0, dn0, "bp");

        // start pulsed during READ, DRAIN and FIN must all be ignored.
        s0 = s_n[0]; r0 = rd_n[0]; dn0 = done_n[0];
        spat = 16'h0215;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            start_s[0] = spat[i];
            ordy[0]    = 1'b1;
        end
        @(negedge clk);
        check("busy_start idle", 32'(busy_s[0]), 32'd0);
        #1;
        expect_frame(0, s0, r0, dn0, "busy_start");

        // Reset after the second handshake aborts the frame.
        s0 = s_n[0];
        @(posedge clk); #1;
        start_s[0] = 1'b1;
        ordy[0]    = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        cyc = 0;
        while (s_n[0] - s0 < 2 && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("rst_mid reached", 32'(s_n[0] - s0 >= 2), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid ctrl", {28'd0, ov[0], read_s[0], busy_s[0], done_s[0]}, 32'd0);
        r0 = rd_n[0]; dn0 = done_n[0];
        repeat (4) @(negedge clk);
        #1;
        check("rst_mid quiet", {ov[0], 31'(rd_n[0] - r0)}, 32'd0);
        check("rst_mid no_done", 32'(done_n[0] - dn0), 32'd0);
        run(0, 1'b0, "rst_restart");

        // Exact multiple: 3x3, three batches.
        run(1, 1'b0, "n9");

        // Random contents and random backpressure against the reference model.
        for (int it = 0; it < 6; it++) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < n_of(d); k++) mem[d][k] = 8'($urandom_range(0, 127));
                run(d, 1'b1, $sformatf("rand%0d_n%0d", it, n_of(d)));
            end
        end

        check("addr_setup_stable", 32'(setup_err[0] + setup_err[1]), 32'd0);
        check("stall_hold", 32'(hold_err[0] + hold_err[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
